// File: rtl/debug_pkg.sv
// Shared types and defaults for the debug access blocks.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HALT = 2'd1,
        ACCESS    = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_RST_CYCLES = 16;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debug_reset_stretch.sv
// Stretches a CPU reset request into a RST_CYCLES-long active-low pulse.
module debug_reset_stretch #(
    parameter int RST_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    output logic cpu_resetn_o
);
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resetn_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(RST_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Leaving system reset behaves like a load: the counter starts full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= CNT_W'(RST_CYCLES);
            resetn_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            resetn_q <= (cnt_d == '0);
        end
    end

    assign cpu_resetn_o = resetn_q;

endmodule

// File: rtl/debug_mem_bridge.sv
// Debug bridge: host memory accesses over NUM_CH channels gated by CPU halt,
// plus single-step and stretched CPU reset.
//   state     | meaning
//   IDLE      | ready for a host request; step may be granted here
//   WAIT_HALT | request latched, holding cpu_halt until the CPU reports halted
//   ACCESS    | channel strobe asserted, waiting for that channel's ack
//   DONE      | one-cycle completion pulse (err on timeout or bad channel)
module debug_mem_bridge
    import debug_pkg::*;
#(
    parameter int  NUM_CH     = DEF_NUM_CH,
    parameter int  ADDR_W     = DEF_ADDR_W,
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  TIMEOUT    = DEF_TIMEOUT,
    parameter int  RST_CYCLES = DEF_RST_CYCLES,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                     cpu_clk,
    input  logic                     sys_rstn,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [CH_W-1:0]          dbg_ch,
    input  logic [ADDR_W-1:0]        dbg_addr,
    input  logic [DATA_W-1:0]        dbg_wdata,
    output logic                     dbg_ready,
    output logic                     dbg_done,
    output logic                     dbg_err,
    output logic [DATA_W-1:0]        dbg_rdata,
    input  logic                     dbg_halt_req,
    input  logic                     dbg_step,
    input  logic                     dbg_reset_req,
    input  logic                     cpu_halted,
    output logic                     cpu_halt,
    output logic                     cpu_resetn,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_we,
    output logic [NUM_CH-1:0]        mem_ce,
    input  logic [NUM_CH*DATA_W-1:0] mem_rdata,
    input  logic [NUM_CH-1:0]        mem_ack
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                done_q, ready_q, halt_q, mem_we_q;
    logic [NUM_CH-1:0]   mem_ce_q;
    logic                step_fire, halt_d;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        to_cnt_d = to_cnt_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dbg_req && ready_q) begin
                    ch_d    = dbg_ch;
                    we_d    = dbg_we;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    if (32'(dbg_ch) >= 32'(NUM_CH)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d  = WAIT_HALT;
                        to_cnt_d = '0;
                    end
                end
            end
            WAIT_HALT: begin
                if (to_cnt_q == TO_W'(TIMEOUT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (cpu_halted) state_d = ACCESS;
                end
            end
            ACCESS: begin
                // An ack arriving on the timeout cycle still completes cleanly.
                if (mem_ack[ch_q]) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata[int'(ch_q)*DATA_W +: DATA_W];
                end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    // Step is only granted from a settled halt, so a held dbg_step cannot chain.
    assign step_fire = dbg_step && !dbg_reset_req && halt_q && dbg_halt_req && cpu_halted
                       && (state_q == IDLE) && (state_d == IDLE);
    assign halt_d    = step_fire ? 1'b0 : (dbg_halt_req || (state_d != IDLE));

    always_ff @(posedge cpu_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            to_cnt_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            halt_q   <= 1'b1;
            mem_we_q <= 1'b0;
            mem_ce_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            to_cnt_q <= to_cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            done_q   <= (state_d == DONE);
            ready_q  <= (state_d == IDLE);
            halt_q   <= halt_d;
            mem_we_q <= (state_d == ACCESS) && we_d;
            mem_ce_q <= (state_d == ACCESS) ? (NUM_CH'(1) << ch_d) : '0;
        end
    end

    debug_reset_stretch #(
        .RST_CYCLES (RST_CYCLES)
    ) u_reset_stretch (
        .clk_i        (cpu_clk),
        .rst_n_i      (sys_rstn),
        .load_i       (dbg_reset_req),
        .cpu_resetn_o (cpu_resetn)
    );

    assign dbg_ready = ready_q;
    assign dbg_done  = done_q;
    assign dbg_err   = err_q;
    assign dbg_rdata = rdata_q;
    assign cpu_halt  = halt_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_ce    = mem_ce_q;

endmodule

// File: tb/tb_debug_mem_bridge.sv
// Directed bench for debug_mem_bridge: a 2-channel default instance and a
// 3-channel instance with a short timeout.
module tb_debug_mem_bridge;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_req, a_we, a_ready, a_done, a_err;
    logic [0:0]  a_ch;
    logic [31:0] a_addr, a_wdata, a_rdata, a_mem_addr, a_mem_wdata;
    logic        a_halt_req, a_step, a_reset_req, a_halted, a_halt, a_resetn, a_mem_we;
    logic [1:0]  a_mem_ce, a_mem_ack;
    logic [63:0] a_mem_rdata;

    logic        b_req, b_we, b_ready, b_done, b_err;
    logic [1:0]  b_ch;
    logic [31:0] b_addr, b_wdata, b_rdata, b_mem_addr, b_mem_wdata;
    logic        b_halt_req, b_step, b_reset_req, b_halted, b_halt, b_resetn, b_mem_we;
    logic [2:0]  b_mem_ce, b_mem_ack;
    logic [95:0] b_mem_rdata;

    debug_mem_bridge u_dut_a (
        .cpu_clk(clk), .sys_rstn(rstn),
        .dbg_req(a_req), .dbg_we(a_we), .dbg_ch(a_ch), .dbg_addr(a_addr), .dbg_wdata(a_wdata),
        .dbg_ready(a_ready), .dbg_done(a_done), .dbg_err(a_err), .dbg_rdata(a_rdata),
        .dbg_halt_req(a_halt_req), .dbg_step(a_step), .dbg_reset_req(a_reset_req),
        .cpu_halted(a_halted), .cpu_halt(a_halt), .cpu_resetn(a_resetn),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_ce(a_mem_ce),
        .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack)
    );

    debug_mem_bridge #(.NUM_CH(3), .TIMEOUT(8)) u_dut_b (
        .cpu_clk(clk), .sys_rstn(rstn),
        .dbg_req(b_req), .dbg_we(b_we), .dbg_ch(b_ch), .dbg_addr(b_addr), .dbg_wdata(b_wdata),
        .dbg_ready(b_ready), .dbg_done(b_done), .dbg_err(b_err), .dbg_rdata(b_rdata),
        .dbg_halt_req(b_halt_req), .dbg_step(b_step), .dbg_reset_req(b_reset_req),
        .cpu_halted(b_halted), .cpu_halt(b_halt), .cpu_resetn(b_resetn),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_ce(b_mem_ce),
        .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack)
    );

    task automatic test_reset();
        @(negedge clk);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", a_ready); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", a_done); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", a_err); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", a_rdata); end
        checks++; if (a_halt !== 1'b1) begin errors++; $display("FAIL rst_halt got %b want 1", a_halt); end
        checks++; if (a_resetn !== 1'b0) begin errors++; $display("FAIL rst_resetn got %b want 0", a_resetn); end
        checks++; if (a_mem_ce !== 2'b00 || a_mem_we !== 1'b0) begin errors++; $display("FAIL rst_strobe got ce=%b we=%b want 00/0", a_mem_ce, a_mem_we); end
        checks++; if (a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr got %h/%h want 0/0", a_mem_addr, a_mem_wdata); end
    endtask

    task automatic test_reset_stretch();
        rstn = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            checks++; if (a_resetn !== 1'b0) begin errors++; $display("FAIL stretch_low%0d got %b want 0", i, a_resetn); end
            if (i == 1) begin
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got %b want 1", a_ready); end
            end
        end
        a_reset_req = 1'b1;
        @(negedge clk);
        a_reset_req = 1'b0;
        checks++; if (a_resetn !== 1'b0) begin errors++; $display("FAIL reload_low got %b want 0", a_resetn); end
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            checks++; if (a_resetn !== (j == 16)) begin errors++; $display("FAIL reload_cyc%0d got %b want %b", j, a_resetn, (j == 16)); end
        end
    endtask

    task automatic test_write();
        a_req = 1'b1; a_we = 1'b1; a_ch = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF; a_mem_ack = 2'b00;
        @(negedge clk);
        a_req = 1'b0;
        checks++; if (a_ready !== 1'b0 || a_mem_ce !== 2'b00 || a_done !== 1'b0) begin errors++; $display("FAIL wr_c1 got rdy=%b ce=%b done=%b want 0/00/0", a_ready, a_mem_ce, a_done); end
        @(negedge clk);
        checks++; if (a_mem_ce !== 2'b10 || a_mem_we !== 1'b1) begin errors++; $display("FAIL wr_strobe got ce=%b we=%b want 10/1", a_mem_ce, a_mem_we); end
        checks++; if (a_mem_addr !== 32'h10 || a_mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus got %h/%h want 10/deadbeef", a_mem_addr, a_mem_wdata); end
        a_mem_ack = 2'b10;
        @(negedge clk);
        a_mem_ack = 2'b00;
        checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL wr_done got done=%b err=%b want 1/0", a_done, a_err); end
        checks++; if (a_mem_ce !== 2'b00 || a_mem_we !== 1'b0) begin errors++; $display("FAIL wr_drop got ce=%b we=%b want 00/0", a_mem_ce, a_mem_we); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", a_rdata); end
        @(negedge clk);
        checks++; if (a_done !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL wr_idle got done=%b rdy=%b want 0/1", a_done, a_ready); end
    endtask

    task automatic test_read_delayed();
        a_req = 1'b1; a_we = 1'b0; a_ch = 1'b0; a_addr = 32'h4;
        a_mem_rdata = {32'hAAAA5555, 32'h12345678};
        @(negedge clk);
        a_req = 1'b0;
        a_mem_ack = 2'b10;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            checks++; if (a_mem_ce !== 2'b01 || a_done !== 1'b0 || a_mem_we !== 1'b0) begin errors++; $display("FAIL rd_wait%0d got ce=%b done=%b we=%b want 01/0/0", c, a_mem_ce, a_done, a_mem_we); end
            if (c == 7) a_mem_ack = 2'b01;
        end
        @(negedge clk);
        a_mem_ack = 2'b00;
        checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL rd_done got done=%b err=%b want 1/0", a_done, a_err); end
        checks++; if (a_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_data got %h want 12345678", a_rdata); end
        @(negedge clk);
        checks++; if (a_done !== 1'b0 || a_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_hold got done=%b data=%h want 0/12345678", a_done, a_rdata); end
    endtask

    task automatic test_back_to_back();
        a_req = 1'b1; a_we = 1'b0; a_ch = 1'b0; a_addr = 32'h8;
        a_mem_rdata[31:0] = 32'h11111111; a_mem_ack = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks++; if (a_done !== 1'b1 || a_rdata !== 32'h11111111) begin errors++; $display("FAIL b2b_first got done=%b data=%h want 1/11111111", a_done, a_rdata); end
            end
            if (c == 4) begin
                checks++; if (a_done !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap got done=%b rdy=%b want 0/1", a_done, a_ready); end
                a_mem_rdata[31:0] = 32'h0000BEEF;
            end
            if (c == 5) begin
                a_req = 1'b0;
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy got rdy=%b want 0", a_ready); end
            end
            if (c == 6) begin
                checks++; if (a_done !== 1'b0 || a_mem_ce !== 2'b01) begin errors++; $display("FAIL b2b_access got done=%b ce=%b want 0/01", a_done, a_mem_ce); end
            end
            if (c == 7) begin
                checks++; if (a_done !== 1'b1 || a_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL b2b_second got done=%b data=%h want 1/0000beef", a_done, a_rdata); end
            end
        end
        a_mem_ack = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_halt_wait();
        a_halt_req = 1'b0; a_halted = 1'b0;
        @(negedge clk);
        checks++; if (a_halt !== 1'b0) begin errors++; $display("FAIL run_halt got %b want 0", a_halt); end
        a_req = 1'b1; a_we = 1'b1; a_ch = 1'b1; a_addr = 32'h20; a_wdata = 32'h5;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) a_req = 1'b0;
            checks++; if (a_halt !== 1'b1 || a_mem_ce !== 2'b00) begin errors++; $display("FAIL hw_wait%0d got halt=%b ce=%b want 1/00", c, a_halt, a_mem_ce); end
        end
        a_halted = 1'b1;
        @(negedge clk);
        checks++; if (a_mem_ce !== 2'b10 || a_halt !== 1'b1) begin errors++; $display("FAIL hw_access got ce=%b halt=%b want 10/1", a_mem_ce, a_halt); end
        a_mem_ack = 2'b10;
        @(negedge clk);
        a_mem_ack = 2'b00;
        checks++; if (a_done !== 1'b1 || a_err !== 1'b0 || a_halt !== 1'b1) begin errors++; $display("FAIL hw_done got done=%b err=%b halt=%b want 1/0/1", a_done, a_err, a_halt); end
        @(negedge clk);
        checks++; if (a_halt !== 1'b0) begin errors++; $display("FAIL hw_release got %b want 0", a_halt); end
        a_halt_req = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_step();
        checks++; if (a_halt !== 1'b1) begin errors++; $display("FAIL step_pre got %b want 1", a_halt); end
        a_step = 1'b1;
        @(negedge clk);
        checks++; if (a_halt !== 1'b0) begin errors++; $display("FAIL step_low got %b want 0", a_halt); end
        @(negedge clk);
        a_step = 1'b0;
        checks++; if (a_halt !== 1'b1) begin errors++; $display("FAIL step_one got %b want 1", a_halt); end
        a_halted = 1'b0; a_step = 1'b1;
        @(negedge clk);
        a_step = 1'b0; a_halted = 1'b1;
        checks++; if (a_halt !== 1'b1) begin errors++; $display("FAIL step_nohalt got %b want 1", a_halt); end
        @(negedge clk);
        a_step = 1'b1; a_reset_req = 1'b1;
        @(negedge clk);
        a_step = 1'b0; a_reset_req = 1'b0;
        checks++; if (a_halt !== 1'b1 || a_resetn !== 1'b0) begin errors++; $display("FAIL step_vs_rst got halt=%b rstn=%b want 1/0", a_halt, a_resetn); end
    endtask

    task automatic test_bad_channel();
        b_req = 1'b1; b_we = 1'b1; b_ch = 2'd3; b_addr = 32'h30; b_wdata = 32'h77;
        @(negedge clk);
        b_req = 1'b0;
        checks++; if (b_done !== 1'b1 || b_err !== 1'b0 + 1'b1) begin errors++; $display("FAIL badch_done got done=%b err=%b want 1/1", b_done, b_err); end
        checks++; if (b_mem_ce !== 3'b000 || b_mem_we !== 1'b0) begin errors++; $display("FAIL badch_strobe got ce=%b we=%b want 000/0", b_mem_ce, b_mem_we); end
        @(negedge clk);
        checks++; if (b_done !== 1'b0 || b_err !== 1'b0 || b_ready !== 1'b1) begin errors++; $display("FAIL badch_idle got done=%b err=%b rdy=%b want 0/0/1", b_done, b_err, b_ready); end
    endtask

    task automatic test_timeout();
        b_req = 1'b1; b_we = 1'b0; b_ch = 2'd2; b_addr = 32'h40;
        b_mem_rdata = {32'hCAFEF00D, 32'h0, 32'h0}; b_mem_ack = 3'b100;
        @(negedge clk);
        b_req = 1'b0;
        @(negedge clk);
        checks++; if (b_mem_ce !== 3'b100) begin errors++; $display("FAIL ch2_strobe got %b want 100", b_mem_ce); end
        @(negedge clk);
        b_mem_ack = 3'b001;
        checks++; if (b_done !== 1'b1 || b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ch2_read got done=%b data=%h want 1/cafef00d", b_done, b_rdata); end
        @(negedge clk);
        b_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) b_req = 1'b0;
            checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL to_early%0d got done=%b want 0", c, b_done); end
            if (c >= 2) begin
                checks++; if (b_mem_ce !== 3'b100) begin errors++; $display("FAIL to_ce%0d got %b want 100", c, b_mem_ce); end
            end
        end
        @(negedge clk);
        checks++; if (b_done !== 1'b1 || b_err !== 1'b1) begin errors++; $display("FAIL to_done got done=%b err=%b want 1/1", b_done, b_err); end
        checks++; if (b_rdata !== 32'h0 || b_mem_ce !== 3'b000) begin errors++; $display("FAIL to_abort got data=%h ce=%b want 0/000", b_rdata, b_mem_ce); end
        b_mem_ack = 3'b000;
        @(negedge clk);
        checks++; if (b_done !== 1'b0 || b_mem_ce !== 3'b000) begin errors++; $display("FAIL to_after got done=%b ce=%b want 0/000", b_done, b_mem_ce); end
    endtask

    task automatic test_reset_mid_access();
        a_req = 1'b1; a_we = 1'b0; a_ch = 1'b0; a_mem_ack = 2'b00;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        checks++; if (a_mem_ce !== 2'b01) begin errors++; $display("FAIL mid_pre got ce=%b want 01", a_mem_ce); end
        rstn = 1'b0;
        #1;
        checks++; if (a_mem_ce !== 2'b00 || a_done !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got ce=%b done=%b rdy=%b want 00/0/0", a_mem_ce, a_done, a_ready); end
        checks++; if (a_halt !== 1'b1 || a_resetn !== 1'b0 || a_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_out got halt=%b rstn=%b data=%h want 1/0/0", a_halt, a_resetn, a_rdata); end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (a_done !== 1'b0 || a_mem_ce !== 2'b00) begin errors++; $display("FAIL mid_after%0d got done=%b ce=%b want 0/00", c, a_done, a_mem_ce); end
        end
    endtask

    initial begin
        rstn = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_ch = '0; a_addr = '0; a_wdata = '0;
        a_halt_req = 1'b1; a_step = 1'b0; a_reset_req = 1'b0; a_halted = 1'b1;
        a_mem_rdata = '0; a_mem_ack = '0;
        b_req = 1'b0; b_we = 1'b0; b_ch = '0; b_addr = '0; b_wdata = '0;
        b_halt_req = 1'b1; b_step = 1'b0; b_reset_req = 1'b0; b_halted = 1'b1;
        b_mem_rdata = '0; b_mem_ack = '0;
        test_reset();
        test_reset_stretch();
        test_write();
        test_read_delayed();
        test_back_to_back();
        test_halt_wait();
        test_step();
        test_bad_channel();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
